// File: rtl/bp_pkg.sv
// Shared branch-prediction types and helpers for the fetch front end.
//   RESET_PC_DEFAULT : default architectural fetch PC after reset
//   pc_t             : 32-bit program counter type
//   PC_STEP          : sequential fetch increment in bytes
//   pc_plus4         : sequential next PC, wraps modulo 2^32
package bp_pkg;

    localparam int unsigned PC_W = 32;

    typedef logic [PC_W-1:0] pc_t;

    localparam pc_t RESET_PC_DEFAULT = 32'hBFC0_0000;
    localparam pc_t PC_STEP          = 32'd4;

    // Sequential successor; the 32-bit add wraps naturally.
    function automatic pc_t pc_plus4(input pc_t pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/pred_queue.sv
// In-order circular FIFO holding outstanding fetch predictions.
//   CLK, RESET  : clock, async active-low reset
//   push / data : enqueue push_data at the tail (ignored when full)
//   pop         : dequeue the head entry (ignored when empty)
//   clear       : drop every entry; has priority over push and pop
//   head_data   : oldest queued prediction
//   full/empty  : occupancy flags
//   count       : current occupancy
module pred_queue
    import bp_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             push,
    input  pc_t              push_data,
    input  logic             pop,
    input  logic             clear,
    output pc_t              head_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    pc_t              mem [DEPTH];
    logic [IDX_W-1:0] head;
    logic [IDX_W-1:0] tail;
    logic             do_push;
    logic             do_pop;

    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == CNT_W'(0));
    assign head_data = mem[head];

    always_comb begin
        do_push = push && !full && !clear;
        do_pop  = pop && !empty && !clear;
    end

    // Pointers wrap for free because DEPTH is a power of two.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (clear) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_push) tail <= tail + IDX_W'(1);
            if (do_pop)  head <= head + IDX_W'(1);
            if (do_push && !do_pop)      count <= count + CNT_W'(1);
            else if (!do_push && do_pop) count <= count - CNT_W'(1);
        end
    end

    // Storage needs no reset; entries are only read when count says valid.
    always_ff @(posedge CLK) begin
        if (do_push) mem[tail] <= push_data;
    end

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch-stage PC generator fed by the return address stack.
//   CLK, RESET      : clock, async active-low reset
//   STALL           : freezes fetch; resolves still proceed
//   RAS_hit/alt_PC  : RAS predicted target for the instruction at PC_IF
//   Resolve_valid/  : EX resolves the oldest in-flight instruction with its
//   Resolve_target    actual next PC
//   PC_IF           : current fetch PC
//   Fetch_valid     : fetch permitted (queue not full), combinational
//   Queue_full      : prediction queue full, combinational
//   Flush           : one-cycle pulse after a detected mispredict
//   Pred_count      : saturating count of RAS-directed fetches
//   Mispred_count   : saturating count of mispredictions
module fetch_pc_gen
    import bp_pkg::*;
#(
    parameter pc_t         RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned QDEPTH   = 4,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             STALL,
    input  logic             RAS_hit,
    input  logic [31:0]      RAS_alt_PC,
    input  logic             Resolve_valid,
    input  logic [31:0]      Resolve_target,
    output logic [31:0]      PC_IF,
    output logic             Fetch_valid,
    output logic             Queue_full,
    output logic             Flush,
    output logic [CNT_W-1:0] Pred_count,
    output logic [CNT_W-1:0] Mispred_count
);

    localparam int unsigned QCNT_W = $clog2(QDEPTH + 1);

    pc_t               head_pc;
    pc_t               pred_pc;
    logic              q_full;
    logic              q_empty;
    logic [QCNT_W-1:0] q_count;
    logic              fetch_ev;
    logic              resolve_ev;
    logic              mispred;
    logic              q_push;
    logic              q_pop;

    assign Queue_full  = q_full;
    assign Fetch_valid = !q_full;

    // Event decode; a mispredict wins over any same-cycle fetch or pop.
    always_comb begin
        pred_pc    = RAS_hit ? RAS_alt_PC : pc_plus4(PC_IF);
        fetch_ev   = Fetch_valid && !STALL;
        resolve_ev = Resolve_valid && (q_count != QCNT_W'(0));
        mispred    = resolve_ev && (head_pc != Resolve_target);
        q_push     = fetch_ev && !mispred;
        q_pop      = resolve_ev && !mispred;
    end

    pred_queue #(
        .DEPTH (QDEPTH)
    ) u_queue (
        .CLK       (CLK),
        .RESET     (RESET),
        .push      (q_push),
        .push_data (pred_pc),
        .pop       (q_pop),
        .clear     (mispred),
        .head_data (head_pc),
        .full      (q_full),
        .empty     (q_empty),
        .count     (q_count)
    );

    // Occupancy flags from the queue must stay coherent with its count.
    assert property (@(posedge CLK) disable iff (!RESET)
        q_empty == (q_count == QCNT_W'(0)));

    // Fetch PC: redirect on mispredict (even when stalled), else advance on fetch.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            PC_IF <= RESET_PC;
        end else if (mispred) begin
            PC_IF <= Resolve_target;
        end else if (fetch_ev) begin
            PC_IF <= pred_pc;
        end
    end

    // Flush and saturating statistics.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            Flush         <= 1'b0;
            Pred_count    <= '0;
            Mispred_count <= '0;
        end else begin
            Flush <= mispred;
            if (q_push && RAS_hit && (Pred_count != {CNT_W{1'b1}})) begin
                Pred_count <= Pred_count + CNT_W'(1);
            end
            if (mispred && (Mispred_count != {CNT_W{1'b1}})) begin
                Mispred_count <= Mispred_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Self-checking bench for fetch_pc_gen: a behavioural model pushes the
// expected post-edge outputs into a scoreboard as each cycle is driven,
// and each test pops and compares after the edge.
module tb_fetch_pc_gen;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        STALL;
    logic        RAS_hit;
    logic [31:0] RAS_alt_PC;
    logic        Resolve_valid;
    logic [31:0] Resolve_target;
    logic [31:0] PC_IF;
    logic        Fetch_valid;
    logic        Queue_full;
    logic        Flush;
    logic [31:0] Pred_count;
    logic [31:0] Mispred_count;

    fetch_pc_gen dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .STALL          (STALL),
        .RAS_hit        (RAS_hit),
        .RAS_alt_PC     (RAS_alt_PC),
        .Resolve_valid  (Resolve_valid),
        .Resolve_target (Resolve_target),
        .PC_IF          (PC_IF),
        .Fetch_valid    (Fetch_valid),
        .Queue_full     (Queue_full),
        .Flush          (Flush),
        .Pred_count     (Pred_count),
        .Mispred_count  (Mispred_count)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [31:0] pc;
        logic        flush;
        logic        full;
        logic        fv;
        logic [31:0] pcnt;
        logic [31:0] mcnt;
    } obs_t;

    localparam logic [31:0] RST_PC = 32'hBFC0_0000;
    localparam int          QD     = 4;

    obs_t        sb[$];
    int          tests_run    = 0;
    int          tests_failed = 0;

    logic [31:0] m_pc;
    logic [31:0] m_q[$];
    logic [31:0] m_pred;
    logic [31:0] m_mis;
    logic        m_flush;

    function automatic obs_t cur_obs();
        obs_t o;
        o.pc    = PC_IF;
        o.flush = Flush;
        o.full  = Queue_full;
        o.fv    = Fetch_valid;
        o.pcnt  = Pred_count;
        o.mcnt  = Mispred_count;
        return o;
    endfunction

    function automatic obs_t reset_obs();
        obs_t o;
        o.pc    = RST_PC;
        o.flush = 1'b0;
        o.full  = 1'b0;
        o.fv    = 1'b1;
        o.pcnt  = '0;
        o.mcnt  = '0;
        return o;
    endfunction

    task automatic model_reset();
        m_pc    = RST_PC;
        m_q.delete();
        m_pred  = '0;
        m_mis   = '0;
        m_flush = 1'b0;
    endtask

    // Drive one cycle of inputs, advance the model, queue the expectation, clock.
    task automatic drive(input logic stall, input logic hit, input logic [31:0] alt,
                         input logic rv, input logic [31:0] rt);
        logic        full_now;
        logic        fetch;
        logic        res;
        logic        mis;
        logic [31:0] pred;
        obs_t        e;
        STALL          = stall;
        RAS_hit        = hit;
        RAS_alt_PC     = alt;
        Resolve_valid  = rv;
        Resolve_target = rt;
        full_now = (m_q.size() == QD);
        fetch    = !full_now && !stall;
        pred     = hit ? alt : m_pc + 32'd4;
        res      = rv && (m_q.size() > 0);
        mis      = res && (m_q[0] != rt);
        m_flush  = mis;
        if (mis) begin
            m_pc = rt;
            m_q.delete();
            if (m_mis != '1) m_mis = m_mis + 1;
        end else begin
            if (res) void'(m_q.pop_front());
            if (fetch) begin
                m_q.push_back(pred);
                m_pc = pred;
                if (hit && m_pred != '1) m_pred = m_pred + 1;
            end
        end
        e.pc    = m_pc;
        e.flush = m_flush;
        e.full  = (m_q.size() == QD);
        e.fv    = (m_q.size() != QD);
        e.pcnt  = m_pred;
        e.mcnt  = m_mis;
        sb.push_back(e);
        @(posedge CLK);
        #1;
    endtask

    // Synchronously placed reset pulse between edges; no checks here.
    task automatic apply_reset();
        RESET = 1'b0;
        #2;
        RESET = 1'b1;
        model_reset();
        sb.delete();
    endtask

    task automatic test_reset();
        obs_t g;
        obs_t e;
        RESET = 1'b0; STALL = 1'b0; RAS_hit = 1'b0; RAS_alt_PC = '0;
        Resolve_valid = 1'b0; Resolve_target = '0;
        #12;
        g = cur_obs(); e = reset_obs();
        tests_run++;
        if (g !== e) begin
            tests_failed++;
            $display("FAIL reset_state got=%h expected=%h", g, e);
        end
        RESET = 1'b1;
        model_reset();
    endtask

    task automatic test_sequential();
        obs_t g;
        obs_t e;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, '0, 1'b0, '0);
            e = sb.pop_front(); g = cur_obs();
            tests_run++;
            if (g !== e) begin
                tests_failed++;
                $display("FAIL seq_step%0d got=%h expected=%h", i, g, e);
            end
            tests_run++;
            if (PC_IF !== RST_PC + 32'(4 * (i + 1))) begin
                tests_failed++;
                $display("FAIL seq_pc%0d got=%h expected=%h", i, PC_IF, RST_PC + 32'(4 * (i + 1)));
            end
        end
        tests_run++;
        if (Pred_count !== 32'd0) begin
            tests_failed++;
            $display("FAIL seq_pred_count got=%0d expected=0", Pred_count);
        end
    endtask

    task automatic test_ras_hit();
        obs_t        g;
        obs_t        e;
        logic [31:0] tgt[3];
        drive(1'b0, 1'b0, '0, 1'b1, 32'hBFC0_0004);
        e = sb.pop_front(); g = cur_obs();
        tests_run++;
        if (g !== e || PC_IF !== 32'hBFC0_0010) begin
            tests_failed++;
            $display("FAIL ras_pre got=%h expected=%h", g, e);
        end
        drive(1'b0, 1'b1, 32'h8000_1234, 1'b1, 32'hBFC0_0008);
        e = sb.pop_front(); g = cur_obs();
        tests_run++;
        if (g !== e || PC_IF !== 32'h8000_1234 || Pred_count !== 32'd1) begin
            tests_failed++;
            $display("FAIL ras_redirect got=%h expected=%h", g, e);
        end
        tgt[0] = 32'hBFC0_000C; tgt[1] = 32'hBFC0_0010; tgt[2] = 32'h8000_1234;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, '0, 1'b1, tgt[i]);
            e = sb.pop_front(); g = cur_obs();
            tests_run++;
            if (g !== e || Flush !== 1'b0 || Mispred_count !== 32'd0) begin
                tests_failed++;
                $display("FAIL ras_resolve%0d got=%h expected=%h", i, g, e);
            end
        end
    endtask

    task automatic test_full();
        obs_t g;
        obs_t e;
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, '0, 1'b0, '0);
            e = sb.pop_front(); g = cur_obs();
            tests_run++;
            if (g !== e) begin
                tests_failed++;
                $display("FAIL full_fill%0d got=%h expected=%h", i, g, e);
            end
        end
        tests_run++;
        if (Queue_full !== 1'b1 || Fetch_valid !== 1'b0 || PC_IF !== 32'h8000_1244) begin
            tests_failed++;
            $display("FAIL full_frozen got full=%b fv=%b pc=%h expected 1 0 80001244",
                     Queue_full, Fetch_valid, PC_IF);
        end
        drive(1'b0, 1'b0, '0, 1'b1, 32'h8000_1238);
        e = sb.pop_front(); g = cur_obs();
        tests_run++;
        if (g !== e || Fetch_valid !== 1'b1 || PC_IF !== 32'h8000_1244) begin
            tests_failed++;
            $display("FAIL full_release got=%h expected=%h", g, e);
        end
        drive(1'b0, 1'b0, '0, 1'b0, '0);
        e = sb.pop_front(); g = cur_obs();
        tests_run++;
        if (g !== e || PC_IF !== 32'h8000_1248) begin
            tests_failed++;
            $display("FAIL full_resume got=%h expected=%h", g, e);
        end
    endtask

    task automatic test_mispredict();
        obs_t g;
        obs_t e;
        apply_reset();
        drive(1'b0, 1'b0, '0, 1'b0, '0);
        e = sb.pop_front(); g = cur_obs();
        tests_run++;
        if (g !== e || PC_IF !== 32'hBFC0_0004) begin
            tests_failed++;
            $display("FAIL mis_setup got=%h expected=%h", g, e);
        end
        drive(1'b0, 1'b1, 32'h8000_0000, 1'b1, 32'hBFC0_0100);
        e = sb.pop_front(); g = cur_obs();
        tests_run++;
        if (g !== e || PC_IF !== 32'hBFC0_0100 || Flush !== 1'b1 ||
            Mispred_count !== 32'd1 || Pred_count !== 32'd0) begin
            tests_failed++;
            $display("FAIL mis_redirect got=%h expected=%h", g, e);
        end
        drive(1'b1, 1'b0, '0, 1'b1, 32'h1111_1110);
        e = sb.pop_front(); g = cur_obs();
        tests_run++;
        if (g !== e || Flush !== 1'b0 || Mispred_count !== 32'd1) begin
            tests_failed++;
            $display("FAIL mis_flush_end got=%h expected=%h", g, e);
        end
    endtask

    task automatic test_stall_mispredict();
        obs_t g;
        obs_t e;
        drive(1'b0, 1'b0, '0, 1'b0, '0);
        e = sb.pop_front(); g = cur_obs();
        tests_run++;
        if (g !== e) begin
            tests_failed++;
            $display("FAIL stall_setup got=%h expected=%h", g, e);
        end
        drive(1'b1, 1'b0, '0, 1'b1, 32'h0040_0000);
        e = sb.pop_front(); g = cur_obs();
        tests_run++;
        if (g !== e || PC_IF !== 32'h0040_0000 || Flush !== 1'b1) begin
            tests_failed++;
            $display("FAIL stall_redirect got=%h expected=%h", g, e);
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, '0, 1'b0, '0);
            e = sb.pop_front(); g = cur_obs();
            tests_run++;
            if (g !== e || PC_IF !== 32'h0040_0000 || Flush !== 1'b0) begin
                tests_failed++;
                $display("FAIL stall_hold%0d got=%h expected=%h", i, g, e);
            end
        end
        drive(1'b0, 1'b0, '0, 1'b0, '0);
        e = sb.pop_front(); g = cur_obs();
        tests_run++;
        if (g !== e || PC_IF !== 32'h0040_0004) begin
            tests_failed++;
            $display("FAIL stall_resume got=%h expected=%h", g, e);
        end
    endtask

    task automatic test_wrap();
        obs_t g;
        obs_t e;
        drive(1'b1, 1'b0, '0, 1'b1, 32'hFFFF_FFFC);
        e = sb.pop_front(); g = cur_obs();
        tests_run++;
        if (g !== e) begin
            tests_failed++;
            $display("FAIL wrap_setup got=%h expected=%h", g, e);
        end
        drive(1'b0, 1'b0, '0, 1'b0, '0);
        e = sb.pop_front(); g = cur_obs();
        tests_run++;
        if (g !== e || PC_IF !== 32'h0000_0000) begin
            tests_failed++;
            $display("FAIL wrap_pc got=%h expected=%h", g, e);
        end
    endtask

    // Mixed random traffic: push/pop overlap walks head and tail around the ring.
    task automatic test_back_to_back();
        obs_t        g;
        obs_t        e;
        logic        hit;
        logic        rv;
        logic        stall;
        logic [31:0] alt;
        logic [31:0] rt;
        for (int i = 0; i < 40; i++) begin
            hit   = 1'($urandom_range(0, 1));
            rv    = ($urandom_range(0, 3) != 0);
            stall = ($urandom_range(0, 5) == 0);
            alt   = {$urandom()} & 32'hFFFF_FFFC;
            rt    = (m_q.size() > 0) ? m_q[0] : 32'h0;
            if ($urandom_range(0, 7) == 0) rt = rt ^ 32'h10;
            drive(stall, hit, alt, rv, rt);
            e = sb.pop_front(); g = cur_obs();
            tests_run++;
            if (g !== e) begin
                tests_failed++;
                $display("FAIL b2b_cycle%0d got=%h expected=%h", i, g, e);
            end
        end
    endtask

    task automatic test_async_reset();
        obs_t g;
        obs_t e;
        apply_reset();
        drive(1'b0, 1'b1, 32'hA000_0000, 1'b0, '0);
        drive(1'b0, 1'b1, 32'hA000_0100, 1'b0, '0);
        drive(1'b0, 1'b0, '0, 1'b0, '0);
        sb.delete();
        tests_run++;
        if (Pred_count !== 32'd2 || PC_IF !== 32'hA000_0104) begin
            tests_failed++;
            $display("FAIL areset_setup got pcnt=%0d pc=%h expected 2 a0000104", Pred_count, PC_IF);
        end
        #2;
        RESET = 1'b0;
        #1;
        g = cur_obs(); e = reset_obs();
        tests_run++;
        if (g !== e) begin
            tests_failed++;
            $display("FAIL areset_immediate got=%h expected=%h", g, e);
        end
        model_reset();
        @(posedge CLK);
        #1;
        RESET = 1'b1;
        drive(1'b1, 1'b0, '0, 1'b1, 32'h0000_1234);
        e = sb.pop_front(); g = cur_obs();
        tests_run++;
        if (g !== e || PC_IF !== RST_PC || Mispred_count !== 32'd0 || Flush !== 1'b0) begin
            tests_failed++;
            $display("FAIL areset_empty_resolve got=%h expected=%h", g, e);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_ras_hit();
        test_full();
        test_mispredict();
        test_stall_mispredict();
        test_wrap();
        test_back_to_back();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/fetch_pc_gen.md
Name: fetch_pc_gen

Overview:
- Fetch-stage PC generator that sits directly downstream of the return address stack (RAS) and consumes its `hit` / `alt_PC` prediction.
- Holds the architectural fetch PC and picks each next PC: RAS target on hit, otherwise PC+4.
- Records every prediction in a small in-order queue. When the execute stage resolves an instruction, compares the actual next PC against the queued prediction; on mismatch, flushes and redirects.
- Keeps saturating statistics counters for RAS-directed predictions and mispredictions.

Parameters:
- RESET_PC, 32'hBFC00000, fetch PC loaded on reset.
- QDEPTH, 4, prediction queue entries; power of two, minimum 2.
- CNT_W, 32, width of the statistics counters.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RESET  in  1  asynchronous, active-low reset.
- STALL  in  1  freezes fetch; does not block resolve.
- RAS_hit  in  1  RAS predicts a return target for the instruction at PC_IF.
- RAS_alt_PC  in  32  RAS predicted target; valid when RAS_hit=1.
- Resolve_valid  in  1  EX resolves the oldest in-flight instruction this cycle.
- Resolve_target  in  32  actual next PC of the resolved instruction.
- PC_IF  out  32  current fetch PC.
- Fetch_valid  out  1  fetch permitted; equals !Queue_full.
- Queue_full  out  1  queue occupancy == QDEPTH.
- Flush  out  1  one-cycle pulse following a detected mispredict.
- Pred_count  out  CNT_W  fetches whose next PC came from the RAS.
- Mispred_count  out  CNT_W  detected mispredictions.

Behaviour:
- Reset (async, RESET=0): PC_IF=RESET_PC; queue empty (head=tail=count=0); Flush=0; both counters=0. Consequently Fetch_valid=1 and Queue_full=0. Reset asserted mid-operation discards all in-flight predictions immediately.
- Fetch event: Fetch_valid & !STALL.
  - pred = RAS_hit ? RAS_alt_PC : PC_IF+4, with mod-2^32 wrap (32'hFFFFFFFC+4 = 0).
  - pred is pushed at the tail and PC_IF <= pred at the same edge. One-cycle latency from inputs to PC_IF.
  - Pred_count increments when RAS_hit=1.
- Resolve event: Resolve_valid & count>0.
  - Pops the head entry and compares it with Resolve_target.
  - Resolve_valid with an empty queue is ignored; no state changes.
- Mispredict (head != Resolve_target), at the same edge:
  - PC_IF <= Resolve_target; queue cleared (count=0, head=tail=0); Flush <= 1 for exactly one cycle; Mispred_count increments.
  - Any simultaneous fetch push is dropped and its Pred_count increment suppressed; the mispredict has priority over fetch.
- Correct prediction: pop only; PC_IF unaffected by the resolve.
- Simultaneous push and correct-pop: count unchanged; head and tail both advance, modulo QDEPTH.
- Full queue: Fetch_valid=0, so no push and PC_IF holds. A resolve in that cycle frees an entry, and fetch resumes the next cycle; there is no same-cycle bypass.
- STALL=1: PC_IF and tail hold; resolves and flushes still proceed. A mispredict during STALL still loads PC_IF.
- Flush is registered: high only in the cycle after the mispredicting resolve edge, and never on two consecutive cycles unless two mispredicts resolve back-to-back.
- Counters saturate at all-ones; no wrap.
- Outputs are registered except Fetch_valid and Queue_full, which are combinational from the registered count.

Decomposition:
- Shared package `bp_pkg`:
  - localparam RESET_PC_DEFAULT.
  - typedef pc_t (32-bit).
  - localparam PC_STEP=4.
  - function pc_plus4.
- One natural sub-module: `pred_queue`, a parameterised circular FIFO.
  - Inputs: push, pop, clear.
  - Outputs: head data, full, empty, count.
  - Same CLK/RESET convention.
- fetch_pc_gen instantiates pred_queue and owns the PC register, compare logic, Flush and the counters.

Test Plan:
- Reset release, STALL=0, RAS_hit=0, no resolves for 3 cycles → PC_IF steps BFC00000, BFC00004, BFC00008, BFC0000C; queue reaches count=3; Pred_count=0.
- PC_IF=BFC00010 with RAS_hit=1, RAS_alt_PC=80001234 → next cycle PC_IF=80001234; Pred_count=1. Then resolve with Resolve_target=80001234 when that entry is head → no Flush; Mispred_count=0.
- 4 fetches with no resolve → Queue_full=1, Fetch_valid=0, PC_IF frozen. One correct resolve → next cycle Fetch_valid=1 and fetch resumes.
- Head prediction BFC00004, Resolve_target=BFC00100, with a fetch in the same cycle → PC_IF=BFC00100; Flush=1 for one cycle; queue empty; Mispred_count=1; the dropped push is not counted.
- STALL=1 held while a mispredicting resolve (Resolve_target=00400000) arrives → PC_IF=00400000 despite STALL; Flush pulses; PC_IF holds until STALL drops.
- Drop RESET mid-stream with 3 entries queued and Pred_count=2 → asynchronously PC_IF=BFC00000, queue empty, counters 0, Flush=0. Resolve_valid on the empty queue afterwards is ignored.
